// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined Rijndael ShiftRows stage with a valid/ready stream
// interface. Supports NB = 4, 6 or 8 state columns (128/192/256-bit blocks).
// The byte permutation is applied combinationally ahead of stage 1. The stages
// behind it only delay the beat, and each stage keeps its own valid bit, so
// bubbles compress under backpressure.
// Optional feature macro: SHIFT_ROWS_INV_EN builds the inverse permutation and
// lets in_inv pick the direction per beat. Without the macro only the forward
// path exists, in_inv is ignored and out_inv is tied low.
module shift_rows_pipe #(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic              out_inv
);

  localparam int W = 32 * NB;

  // Reject unsupported configurations while elaborating.
  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
      $error("shift_rows_pipe: PIPE_STAGES must be in 1..4");
    end
  endgenerate

  // Row rotation amount. The 256-bit block uses larger shifts on rows 2 and 3.
  function automatic int row_shift(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  // Byte s[r][c] sits at bit W-1-8*(4c+r). Each output byte gathers its
  // source column: c+sh going forward, c-sh going backward (mod NB).
  function automatic logic [W-1:0] shift_state(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] s;
    int sh;
    int src;
    s = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        sh  = row_shift(r);
        src = inv ? (c + NB - sh) % NB : (c + sh) % NB;
        s[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
      end
    end
    return s;
  endfunction

  logic inv_sel;

`ifdef SHIFT_ROWS_INV_EN
  assign inv_sel = in_inv;
`else
  // Forward-only build: the direction input is deliberately left dangling.
  logic unused_in_inv;
  assign inv_sel       = 1'b0;
  assign unused_in_inv = in_inv;
`endif

  // Index 0 is the input side of the chain; index i is the output of stage i.
  logic [PIPE_STAGES:0]        stage_v;
  logic [PIPE_STAGES:0][W-1:0] stage_data;
  logic [PIPE_STAGES:0]        stage_inv;
  logic [PIPE_STAGES:1]        stage_ready;

  assign stage_v[0]    = in_valid;
  assign stage_data[0] = shift_state(in_data, inv_sel);
  assign stage_inv[0]  = inv_sel;

  genvar gi;
  generate
    for (gi = 1; gi <= PIPE_STAGES; gi++) begin : g_stage
      logic         v_reg;
      logic [W-1:0] data_reg;
      logic         inv_reg;

      // Stage i can load unless it and every stage after it are full and the
      // sink is stalled. This is the unrolled form of !v[i] || ready[i+1].
      assign stage_ready[gi] = out_ready | ~(&stage_v[PIPE_STAGES:gi]);

      // Advance the beat when ready. The payload moves only with a valid beat,
      // which keeps idle stages from toggling.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg    <= 1'b0;
          data_reg <= '0;
          inv_reg  <= 1'b0;
        end else if (stage_ready[gi]) begin
          v_reg <= stage_v[gi-1];
          if (stage_v[gi-1]) begin
            data_reg <= stage_data[gi-1];
            inv_reg  <= stage_inv[gi-1];
          end
        end
      end

      assign stage_v[gi]    = v_reg;
      assign stage_data[gi] = data_reg;
      assign stage_inv[gi]  = inv_reg;
    end
  endgenerate

  assign in_ready  = stage_ready[1];
  assign out_valid = stage_v[PIPE_STAGES];
  assign out_data  = stage_data[PIPE_STAGES];
  assign out_inv   = stage_inv[PIPE_STAGES];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: drives two instances of shift_rows_pipe.
//   dut_a : NB=4, PIPE_STAGES=1
//   dut_b : NB=8, PIPE_STAGES=3
// A byte-array reference model predicts each accepted beat, and a per-cycle
// scoreboard compares the DUT outputs against it. Directed vectors with
// literal answers pin both the model and the DUTs.
module tb_shift_rows_pipe;

  logic clk;
  logic rst_n;

  logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
  logic [127:0] a_in_data, a_out_data;
  logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
  logic [255:0] b_in_data, b_out_data;

  int checks = 0;
  int errors = 0;

  shift_rows_pipe #(.NB(4), .PIPE_STAGES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_inv(a_out_inv)
  );

  shift_rows_pipe #(.NB(8), .PIPE_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_inv(b_out_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: state as a flat byte list, k = 4c + r, first byte in the MSBs.
  // Forward gathers from column c+sh. Inverse scatters to column c+sh.
  function automatic logic [255:0] model(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0]   b[32];
    logic [7:0]   o[32];
    logic [255:0] res;
    int           sh;
    for (int k = 0; k < 32; k++) begin
      b[k] = 8'h00;
      o[k] = 8'h00;
    end
    for (int k = 0; k < 4 * nb; k++) b[k] = d[8*(4*nb-1-k) +: 8];
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        sh = (nb == 8 && r > 1) ? r + 1 : r;
        if (!inv) o[4*c+r] = b[4*((c+sh)%nb)+r];
        else      o[4*((c+sh)%nb)+r] = b[4*c+r];
      end
    end
    res = '0;
    for (int k = 0; k < 4 * nb; k++) res[8*(4*nb-1-k) +: 8] = o[k];
    return res;
  endfunction

  function automatic bit eff_inv(input logic i);
`ifdef SHIFT_ROWS_INV_EN
    return i;
`else
    return 1'b0 & i;
`endif
  endfunction

  // Scoreboards: the expected results of beats currently inside each pipe.
  logic [255:0] a_q[$];
  bit           a_iq[$];
  logic [255:0] b_q[$];
  bit           b_iq[$];
  int           a_rx = 0;
  int           b_rx = 0;
  bit           a_stall = 0, b_stall = 0;
  logic [255:0] a_hold, b_hold;
  logic         a_hold_inv, b_hold_inv;

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_q.delete(); a_iq.delete(); b_q.delete(); b_iq.delete();
      a_stall = 0; b_stall = 0;
    end else begin
      // ---- dut_a ----
      if (a_stall) chk("a_stall_hold", {a_out_valid, a_out_inv, a_out_data}, {1'b1, a_hold_inv, a_hold[127:0]});
      chk("a_in_ready", a_in_ready, (a_out_ready || a_q.size() < 1));
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_extra_beat: got out_valid=1 expected no beat in flight");
        end else begin
          chk("a_beat_data", a_out_data, a_q.pop_front());
          chk("a_beat_inv", a_out_inv, a_iq.pop_front());
        end
        a_rx++;
      end
      a_stall = a_out_valid && !a_out_ready;
      a_hold = a_out_data; a_hold_inv = a_out_inv;
      if (a_in_valid && a_in_ready) begin
        a_q.push_back(model(a_in_data, 4, eff_inv(a_in_inv)));
        a_iq.push_back(eff_inv(a_in_inv));
      end
      // ---- dut_b ----
      if (b_stall) chk("b_stall_hold", {b_out_valid, b_out_inv, b_out_data}, {1'b1, b_hold_inv, b_hold});
      chk("b_in_ready", b_in_ready, (b_out_ready || b_q.size() < 3));
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra_beat: got out_valid=1 expected no beat in flight");
        end else begin
          chk("b_beat_data", b_out_data, b_q.pop_front());
          chk("b_beat_inv", b_out_inv, b_iq.pop_front());
        end
        b_rx++;
      end
      b_stall = b_out_valid && !b_out_ready;
      b_hold = b_out_data; b_hold_inv = b_out_inv;
      if (b_in_valid && b_in_ready) begin
        b_q.push_back(model(b_in_data, 8, eff_inv(b_in_inv)));
        b_iq.push_back(eff_inv(b_in_inv));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] seq8;
  logic [127:0] alt_d;
  bit           alt_i;
  bit [3:0]     pat;
  bit           exp_b;
  int           sent, rx0, cyc, stall_left;
  bit           first, acc, saw_blocked;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_in_inv = 0; a_in_data = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_inv = 0; b_in_data = '0; b_out_ready = 1;

    // The model itself, pinned against hand-computed vectors.
    chk("model_fwd4", model(256'hac73cf7befc111df13b5d6b545235ab8, 4, 0), 256'hacc1d6b8efb55a7b1323cfdf457311b5);
    chk("model_inv4", model(256'hacc1d6b8efb55a7b1323cfdf457311b5, 4, 1), 256'hac73cf7befc111df13b5d6b545235ab8);
    chk("model_seq4", model(256'h000102030405060708090a0b0c0d0e0f, 4, 0), 256'h00050a0f04090e03080d02070c01060b);

    // Reset state.
    #2;
    chk("rst_a_out", {a_out_valid, a_out_inv, a_out_data}, '0);
    chk("rst_b_out", {b_out_valid, b_out_inv, b_out_data}, '0);
    chk("rst_in_ready", {a_in_ready, b_in_ready}, 2'b11);
    step(); step();
    rst_n = 1'b1;

    // Forward, NB=4, single stage: the result shows up after one edge.
    a_in_valid = 1; a_in_inv = 0; a_in_data = 128'hac73cf7befc111df13b5d6b545235ab8;
    step();
    chk("fwd4_valid", a_out_valid, 1'b1);
    chk("fwd4_data", a_out_data, 128'hacc1d6b8efb55a7b1323cfdf457311b5);
    chk("fwd4_inv", a_out_inv, 1'b0);
    a_in_data = 128'h000102030405060708090a0b0c0d0e0f;
    step();
    chk("fwd4_seq", a_out_data, 128'h00050a0f04090e03080d02070c01060b);

    // Inverse request. Without the feature it is treated as forward.
    a_in_inv = 1; a_in_data = 128'hacc1d6b8efb55a7b1323cfdf457311b5;
    step();
`ifdef SHIFT_ROWS_INV_EN
    chk("inv4_data", a_out_data, 128'hac73cf7befc111df13b5d6b545235ab8);
    chk("inv4_inv", a_out_inv, 1'b1);
`else
    chk("inv4_data", a_out_data, model(256'hacc1d6b8efb55a7b1323cfdf457311b5, 4, 0));
    chk("inv4_inv", a_out_inv, 1'b0);
`endif

    // Back-to-back alternating modes.
    for (int i = 0; i < 6; i++) begin
      alt_d = {$urandom(), $urandom(), $urandom(), $urandom()};
      alt_i = i[0];
      a_in_data = alt_d; a_in_inv = alt_i;
      step();
      chk("alt_beat", a_out_data, model(alt_d, 4, eff_inv(alt_i)));
      chk("alt_inv", a_out_inv, eff_inv(alt_i));
    end
    a_in_valid = 0; a_in_inv = 0;
    step();

    // NB=8 with bytes 00..1f. Three-stage latency is checked edge by edge.
    for (int k = 0; k < 32; k++) seq8[255-8*k -: 8] = k[7:0];
    b_in_valid = 1; b_in_inv = 0; b_in_data = seq8;
    step();
    b_in_valid = 0;
    chk("nb8_lat_e0", b_out_valid, 1'b0);
    step();
    chk("nb8_lat_e1", b_out_valid, 1'b0);
    step();
    chk("nb8_lat_e2", b_out_valid, 1'b1);
    chk("nb8_col0", b_out_data[255 -: 32], 32'h00050e13);
    chk("nb8_col1", b_out_data[223 -: 32], 32'h04091217);
    chk("nb8_all", b_out_data, model(seq8, 8, 0));
    step();

    // Backpressure: stream 10 beats and stall the sink for 5 cycles once
    // the first beat reaches the output.
    sent = 0; rx0 = b_rx; cyc = 0; first = 0; stall_left = 0; saw_blocked = 0;
    while ((sent < 10 || b_rx - rx0 < 10) && cyc < 200) begin
      if (!first && b_out_valid) begin
        first = 1;
        stall_left = 5;
      end
      b_out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      b_in_valid = (sent < 10);
      b_in_inv   = sent[0];
      b_in_data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
      #2;
      acc = b_in_valid && b_in_ready;
      if (!b_in_ready) saw_blocked = 1;
      step();
      if (acc) sent++;
      cyc++;
    end
    b_in_valid = 0; b_out_ready = 1;
    chk("bp_sent", sent, 10);
    chk("bp_received", b_rx - rx0, 10);
    chk("bp_in_ready_low", saw_blocked, 1'b1);
    step(); step();

    // Bubbles: valid pattern 1,0,1,0 on both pipes with the sink always ready.
    pat = 4'b0101;
    for (int j = 0; j < 8; j++) begin
      a_in_valid = (j < 4) ? pat[j] : 1'b0;
      b_in_valid = (j < 4) ? pat[j] : 1'b0;
      a_in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_in_data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
      step();
      chk("bubble_a", a_out_valid, (j < 4) ? pat[j] : 1'b0);
      exp_b = (j >= 2 && j < 6) ? pat[j-2] : 1'b0;
      chk("bubble_b", b_out_valid, exp_b);
    end
    a_in_valid = 0; b_in_valid = 0;
    step();

    // Asynchronous reset with two beats in flight, one already at the output.
    b_in_valid = 1; b_in_data = seq8;
    step();
    b_in_data = ~seq8;
    step();
    b_in_valid = 0;
    step();
    chk("arst_pre_valid", b_out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_b_out", {b_out_valid, b_out_inv, b_out_data}, '0);
    chk("arst_a_out", {a_out_valid, a_out_inv, a_out_data}, '0);
    chk("arst_in_ready", {a_in_ready, b_in_ready}, 2'b11);
    step(); step();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("post_rst_quiet", {a_out_valid, b_out_valid}, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
